// File: rtl/i2s_playback_sequencer.sv
// Playback sequencer for the Pi-filled sample buffer: tracks the fill level, paces one pop per
// sample period, and drives the refill interrupt, mute, underrun and overflow status.
module i2s_playback_sequencer #(
    parameter int DEPTH      = 64,
    parameter int LEVEL_W    = 7,
    parameter int SAMPLE_DIV = 1024,
    parameter int PREFILL    = 32,
    parameter int LOW_WM     = 16,
    parameter int HIGH_WM    = 48
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               wr_word,
    output logic               sample_pop,
    output logic               rpi_interrupt,
    output logic               mute,
    output logic [LEVEL_W-1:0] fill_level,
    output logic               overflow,
    output logic [7:0]         underrun_cnt,
    output logic [1:0]         state_dbg
);

    localparam int DIV_W = $clog2(SAMPLE_DIV);

    localparam logic [DIV_W-1:0]   C_DIV_MAX = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [LEVEL_W-1:0] C_DEPTH   = LEVEL_W'(DEPTH);
    localparam logic [LEVEL_W-1:0] C_PREFILL = LEVEL_W'(PREFILL);
    localparam logic [LEVEL_W-1:0] C_LOW_WM  = LEVEL_W'(LOW_WM);
    localparam logic [LEVEL_W-1:0] C_HIGH_WM = LEVEL_W'(HIGH_WM);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PREFILL  = 2'd1;
    localparam logic [1:0] S_PLAY     = 2'd2;
    localparam logic [1:0] S_UNDERRUN = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [DIV_W-1:0]   r_div;
    logic [LEVEL_W-1:0] r_level;
    logic [7:0]         r_ucnt;
    logic               r_pop;
    logic               r_irq;
    logic               r_mute;
    logic               r_ovf;
    logic               w_tick;
    logic               w_pop;
    logic               w_enter_play;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        w_tick       = ((r_state == S_PLAY) || (r_state == S_UNDERRUN)) && (r_div == C_DIV_MAX);
        // A pop decided in a PLAY tick completes even if enable drops in the same cycle.
        w_pop        = (r_state == S_PLAY) && w_tick && (r_level != '0);
        w_next       = r_state;
        if (!enable) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:                w_next = S_PREFILL;
                S_PREFILL, S_UNDERRUN: if (r_level >= C_PREFILL) w_next = S_PLAY;
                S_PLAY:                if (w_tick && (r_level == '0)) w_next = S_UNDERRUN;
                default:               w_next = S_IDLE;
            endcase
        end
        w_enter_play = (w_next == S_PLAY) && (r_state != S_PLAY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_level <= '0;
            r_ucnt  <= '0;
            r_pop   <= 1'b0;
            r_irq   <= 1'b0;
            r_mute  <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pop   <= w_pop;
            r_mute  <= (w_next != S_PLAY);

            if (w_enter_play || !((w_next == S_PLAY) || (w_next == S_UNDERRUN)) || w_tick)
                r_div <= '0;
            else
                r_div <= r_div + 1'b1;

            // Simultaneous write and pop cancel out, so a full buffer never overflows then.
            case ({wr_word, w_pop})
                2'b10:   if (r_level != C_DEPTH) r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase

            if ((r_state == S_IDLE) && (w_next == S_PREFILL))
                r_ovf <= 1'b0;
            else if (wr_word && !w_pop && (r_level == C_DEPTH))
                r_ovf <= 1'b1;

            if ((r_state == S_PLAY) && (w_next == S_UNDERRUN))
                r_ucnt <= sat_inc8(r_ucnt);

            // Watermark hysteresis only applies while already playing.
            case (w_next)
                S_IDLE:  r_irq <= 1'b0;
                S_PLAY: begin
                    if (w_enter_play)             r_irq <= 1'b1;
                    else if (r_level <= C_LOW_WM)  r_irq <= 1'b1;
                    else if (r_level >= C_HIGH_WM) r_irq <= 1'b0;
                end
                default: r_irq <= 1'b1;
            endcase
        end
    end

    assign sample_pop    = r_pop;
    assign rpi_interrupt = r_irq;
    assign mute          = r_mute;
    assign fill_level    = r_level;
    assign overflow      = r_ovf;
    assign underrun_cnt  = r_ucnt;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_i2s_playback_sequencer.sv
// Directed bench for i2s_playback_sequencer: stimulus pushes the expected fill level of each
// upcoming pop into a scoreboard that a monitor pops whenever sample_pop fires.
module tb_i2s_playback_sequencer;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       wr_word;
    logic       sample_pop;
    logic       rpi_interrupt;
    logic       mute;
    logic [6:0] fill_level;
    logic       overflow;
    logic [7:0] underrun_cnt;
    logic [1:0] state_dbg;

    int vec = 0;
    int err = 0;
    int exp_q[$];

    i2s_playback_sequencer #(
        .DEPTH(64), .LEVEL_W(7), .SAMPLE_DIV(8), .PREFILL(32), .LOW_WM(16), .HIGH_WM(48)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr_word(wr_word),
        .sample_pop(sample_pop), .rpi_interrupt(rpi_interrupt), .mute(mute),
        .fill_level(fill_level), .overflow(overflow), .underrun_cnt(underrun_cnt),
        .state_dbg(state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_down(input int from, input int to);
        for (int v = from; v >= to; v--) exp_q.push_back(v);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state_dbg, 0);
        chk({tag, "_pop"}, sample_pop, 0);
        chk({tag, "_irq"}, rpi_interrupt, 0);
        chk({tag, "_mute"}, mute, 1);
        chk({tag, "_level"}, fill_level, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_ucnt"}, underrun_cnt, 0);
    endtask

    always @(posedge clk) begin
        #1;
        if (sample_pop === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_level", fill_level, 999);
            end else begin
                chk("pop_level", fill_level, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n   = 1'b1;
        enable  = 1'b0;
        wr_word = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("por");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        enable = 1'b1;

        // prefill: 32 words, then the level latch takes PLAY one edge later
        cyc(1);
        chk("prefill_state", state_dbg, 1);
        chk("prefill_irq", rpi_interrupt, 1);
        chk("prefill_mute", mute, 1);
        wr_word = 1'b1;
        cyc(32);
        chk("prefill_lvl32", fill_level, 32);
        chk("prefill_hold_state", state_dbg, 1);
        cyc(1);
        chk("play_state", state_dbg, 2);
        chk("play_mute", mute, 0);
        chk("play_irq", rpi_interrupt, 1);
        cyc(7);
        wr_word = 1'b0;
        chk("play_lvl40", fill_level, 40);

        // drain 40 -> 16, one pop every 8 cycles
        push_down(39, 16);
        cyc(185);
        chk("drain_lvl16", fill_level, 16);
        chk("drain_irq", rpi_interrupt, 1);

        // refill to 48 with writes that collide with four pops
        exp_q.push_back(23);
        exp_q.push_back(30);
        exp_q.push_back(37);
        exp_q.push_back(44);
        wr_word = 1'b1;
        cyc(36);
        wr_word = 1'b0;
        chk("fill_lvl48", fill_level, 48);
        chk("fill_irq_pre", rpi_interrupt, 1);
        push_down(47, 16);
        cyc(1);
        chk("fill_irq_clear", rpi_interrupt, 0);
        cyc(251);
        chk("lowwm_lvl16", fill_level, 16);
        chk("lowwm_irq_prev", rpi_interrupt, 0);
        cyc(1);
        chk("lowwm_irq_set", rpi_interrupt, 1);

        // drain to empty, then underrun
        push_down(15, 0);
        cyc(134);
        chk("empty_state", state_dbg, 2);
        chk("empty_lvl", fill_level, 0);
        chk("empty_ucnt", underrun_cnt, 0);
        cyc(1);
        chk("ur_state", state_dbg, 3);
        chk("ur_mute", mute, 1);
        chk("ur_ucnt", underrun_cnt, 1);
        chk("ur_irq", rpi_interrupt, 1);
        chk("ur_pop", sample_pop, 0);
        wr_word = 1'b1;
        cyc(32);
        wr_word = 1'b0;
        chk("ur_refill_lvl", fill_level, 32);
        chk("ur_refill_state", state_dbg, 3);
        cyc(1);
        chk("resume_state", state_dbg, 2);
        chk("resume_mute", mute, 0);

        // fill to 64, then write with a pop and write alone at full
        exp_q.push_back(39);
        exp_q.push_back(46);
        exp_q.push_back(53);
        exp_q.push_back(60);
        wr_word = 1'b1;
        cyc(36);
        wr_word = 1'b0;
        chk("full_lvl", fill_level, 64);
        chk("full_ovf", overflow, 0);
        cyc(3);
        wr_word = 1'b1;
        exp_q.push_back(64);
        cyc(1);
        chk("wrpop_pop", sample_pop, 1);
        chk("wrpop_lvl", fill_level, 64);
        chk("wrpop_ovf", overflow, 0);
        cyc(1);
        wr_word = 1'b0;
        chk("ovf_lvl", fill_level, 64);
        chk("ovf_set", overflow, 1);
        push_down(63, 40);
        cyc(7);
        chk("ovf_sticky", overflow, 1);
        cyc(184);
        chk("pre_idle_lvl", fill_level, 40);

        // disable mid-PLAY away from a tick
        cyc(2);
        enable = 1'b0;
        cyc(1);
        chk("idle_state", state_dbg, 0);
        chk("idle_irq", rpi_interrupt, 0);
        chk("idle_mute", mute, 1);
        chk("idle_lvl", fill_level, 40);
        chk("idle_ovf", overflow, 1);
        chk("idle_ucnt", underrun_cnt, 1);
        cyc(20);
        chk("idle_hold_lvl", fill_level, 40);
        enable = 1'b1;
        cyc(1);
        chk("reen_state", state_dbg, 1);
        chk("reen_ovf_clr", overflow, 0);
        cyc(1);
        chk("reen_play", state_dbg, 2);
        exp_q.push_back(39);
        cyc(8);
        chk("rst_pre_pop", sample_pop, 1);

        // async reset between edges while a pop strobe is high
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("async");
        cyc(3);
        chk_reset_vals("held");
        chk("sb_drain", exp_q.size(), 0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
